rx_mac_interface: RTL and testbench
===================================

RX_MAC_INTERFACE -- requirements
Module: rx_mac_interface

Interface
REQ-001 SHALL have port: clk  in  1  sole clock; all logic on rising edge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-high; sampled on clk.
REQ-003 SHALL have port: rx_data  in  64  MAC receive data; byte 0 in [7:0].
REQ-004 SHALL have port: rx_data_valid  in  8  per-byte valid mask, contiguous from bit 0; 0 = idle beat.
REQ-005 SHALL have port: rx_good_frame  in  1  one-cycle pulse after the last beat of an FCS-good frame.
REQ-006 SHALL have port: rx_bad_frame  in  1  one-cycle pulse after the last beat of a bad frame.
REQ-007 SHALL have port: wr_addr  out  9  internal 512x64 memory write address.
REQ-008 SHALL have port: wr_data  out  64  memory write data.
REQ-009 SHALL have port: wr_en  out  1  memory write strobe.
REQ-010 SHALL have port: commited_wr_addr  out  10  qword pointer with wrap bit; first slot not yet committed.
REQ-011 SHALL have port: commited_rd_addr  in  10  consumer's released pointer; same format.
REQ-012 SHALL have port: dropped_frames  out  32  count of discarded frames.

Function
REQ-013 Buffer layout per frame SHALL be: header qword at sof, data qwords at sof+1..sof+N; header = {byte_count[31:0], 32'h0}.
REQ-014 All pointers SHALL be 10 bits and wrap mod 1024; wr_addr SHALL be pointer[8:0].
REQ-015 Occupancy SHALL be (ptr - commited_rd_addr) mod 1024; a write to ptr is legal only if occupancy < 512.
REQ-016 FSM states SHALL be IDLE, RECV, COMMIT, DROP.
REQ-017 IDLE, rx_data_valid != 0, slots sof and sof+1 both legal: sof <= commited_wr_addr; write beat to sof+1; byte_count <= popcount(mask); -> RECV.
REQ-018 IDLE, rx_data_valid != 0, insufficient space: no write; -> DROP.
REQ-019 RECV, rx_data_valid != 0: write to next slot, byte_count += popcount(mask); if slot not legal, suppress the write -> DROP.
REQ-020 RECV, rx_good_frame: -> COMMIT.
REQ-021 RECV, rx_bad_frame: no header write; commited_wr_addr unchanged (slots reused); dropped_frames += 1; -> IDLE.
REQ-022 COMMIT (exactly one cycle): wr_en=1, wr_addr=sof[8:0], wr_data={byte_count,32'h0}; commited_wr_addr <= sof + 1 + N; -> IDLE.
REQ-023 Latency: commited_wr_addr SHALL change on the 2nd rising edge after the edge sampling rx_good_frame; header is written on the 1st.
REQ-024 commited_wr_addr SHALL never move except in COMMIT; a partial frame SHALL never become visible.
REQ-025 DROP: wr_en=0; wait for rx_good_frame or rx_bad_frame; then dropped_frames += 1 -> IDLE.
REQ-026 rx_data_valid != 0 in COMMIT (IFG violation): that frame SHALL be discarded via DROP; the committed frame is unaffected.
REQ-027 rx_good_frame/rx_bad_frame in IDLE SHALL be ignored.
REQ-028 Simultaneous rx_good_frame and rx_bad_frame SHALL be treated as bad.
REQ-029 dropped_frames SHALL wrap at 2^32.
REQ-030 wr_en SHALL be 0 on every cycle not listed in REQ-017/019/022.

Reset
REQ-031 During reset: wr_en=0, wr_addr=0, wr_data=0, commited_wr_addr=0, dropped_frames=0, byte_count=0, FSM=IDLE.
REQ-032 Reset mid-frame SHALL discard the frame without incrementing dropped_frames; outputs take reset values on the following edge.
REQ-033 After deassertion, the first beat SHALL be accepted on the first clk edge with reset low.

Verification
REQ-034 60-byte good frame (7 full beats + mask 8'h0F), empty buffer -> data at 1..8, header {32'd60,32'h0} at 0, commited_wr_addr 0 -> 9.
REQ-035 Bad frame of 10 beats after REQ-034 -> no header write, commited_wr_addr stays 9, dropped_frames = 1; next good frame starts with sof = 9.
REQ-036 commited_rd_addr=0, commited_wr_addr=500, 20-beat frame -> overflow at slot 512, enters DROP, no write at slot 512, dropped_frames +1, commited_wr_addr stays 500.
REQ-037 Wrap: commited_rd_addr=1000, commited_wr_addr=1020, 8-beat good frame -> wr_addr 508..511 then 0..4, commited_wr_addr = 5.
REQ-038 Reset asserted at beat 3 of a frame -> all outputs 0 next edge, dropped_frames 0; following good frame lands at sof 0.
REQ-039 New beat in the COMMIT cycle -> header still written correctly, second frame dropped, dropped_frames +1.

Source files
------------

// File: rtl/rx_mac_interface.sv
// Receive MAC to circular qword buffer bridge. Each frame is stored as a header qword
// followed by its data qwords; a frame is published only after its header has been written.
module rx_mac_interface (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] rx_data,
    input  logic [7:0]  rx_data_valid,
    input  logic        rx_good_frame,
    input  logic        rx_bad_frame,
    output logic [8:0]  wr_addr,
    output logic [63:0] wr_data,
    output logic        wr_en,
    output logic [9:0]  commited_wr_addr,
    input  logic [9:0]  commited_rd_addr,
    output logic [31:0] dropped_frames,
    output logic [1:0]  state_dbg
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RECV   = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;
    localparam logic [1:0] DROP   = 2'd3;

    // Handshake: there is no backpressure. A beat is any cycle with rx_data_valid != 0;
    // the frame ends with a one-cycle rx_good_frame / rx_bad_frame pulse after the last beat.

    logic [1:0]  state;
    logic [8:0]  sof_addr;
    logic [9:0]  wr_ptr;
    logic [9:0]  free_ptr;
    logic [31:0] byte_count;
    logic        commit_pending;

    logic        beat;
    logic        end_bad;
    logic        end_good;
    logic [3:0]  beat_bytes;
    logic [9:0]  first_slot;

    function automatic logic [3:0] popcount8(input logic [7:0] m);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) n = n + {3'd0, m[i]};
        return n;
    endfunction

    function automatic logic slot_ok(input logic [9:0] p, input logic [9:0] rd);
        logic [9:0] occ;
        occ = p - rd;
        return !occ[9];
    endfunction

    always_comb begin
        beat       = |rx_data_valid;
        end_bad    = rx_bad_frame;
        end_good   = rx_good_frame & ~rx_bad_frame;
        beat_bytes = popcount8(rx_data_valid);
        first_slot = free_ptr + 10'd1;
    end

    assign state_dbg = state;

    // free_ptr moves in COMMIT; the visible pointer follows one edge later so a consumer
    // never sees it before the header write has landed in memory.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            sof_addr         <= 9'd0;
            wr_ptr           <= 10'd0;
            free_ptr         <= 10'd0;
            byte_count       <= 32'd0;
            commit_pending   <= 1'b0;
            wr_en            <= 1'b0;
            wr_addr          <= 9'd0;
            wr_data          <= 64'd0;
            commited_wr_addr <= 10'd0;
            dropped_frames   <= 32'd0;
        end else begin
            wr_en          <= 1'b0;
            commit_pending <= 1'b0;
            if (commit_pending) commited_wr_addr <= free_ptr;

            case (state)
                IDLE: begin
                    if (beat) begin
                        if (slot_ok(free_ptr, commited_rd_addr) &&
                            slot_ok(first_slot, commited_rd_addr)) begin
                            sof_addr   <= free_ptr[8:0];
                            wr_en      <= 1'b1;
                            wr_addr    <= first_slot[8:0];
                            wr_data    <= rx_data;
                            byte_count <= {28'd0, beat_bytes};
                            wr_ptr     <= first_slot + 10'd1;
                            state      <= RECV;
                        end else begin
                            state <= DROP;
                        end
                    end
                end
                RECV: begin
                    if (end_bad) begin
                        dropped_frames <= dropped_frames + 32'd1;
                        state          <= IDLE;
                    end else if (end_good) begin
                        state <= COMMIT;
                    end else if (beat) begin
                        if (slot_ok(wr_ptr, commited_rd_addr)) begin
                            wr_en      <= 1'b1;
                            wr_addr    <= wr_ptr[8:0];
                            wr_data    <= rx_data;
                            byte_count <= byte_count + {28'd0, beat_bytes};
                            wr_ptr     <= wr_ptr + 10'd1;
                        end else begin
                            state <= DROP;
                        end
                    end
                end
                COMMIT: begin
                    wr_en          <= 1'b1;
                    wr_addr        <= sof_addr;
                    wr_data        <= {byte_count, 32'h0};
                    free_ptr       <= wr_ptr;
                    commit_pending <= 1'b1;
                    // A beat here violated the inter-frame gap; that frame is discarded.
                    state          <= beat ? DROP : IDLE;
                end
                default: begin
                    if (rx_good_frame || rx_bad_frame) begin
                        dropped_frames <= dropped_frames + 32'd1;
                        state          <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_mac_interface.sv
// Directed bench for rx_mac_interface: stimulus pushes expected memory writes into a queue,
// a negedge monitor pops and compares every wr_en cycle.
module tb_rx_mac_interface;

    logic        clk;
    logic        reset;
    logic [63:0] rx_data;
    logic [7:0]  rx_data_valid;
    logic        rx_good_frame;
    logic        rx_bad_frame;
    logic [8:0]  wr_addr;
    logic [63:0] wr_data;
    logic        wr_en;
    logic [9:0]  commited_wr_addr;
    logic [9:0]  commited_rd_addr;
    logic [31:0] dropped_frames;
    logic [1:0]  state_dbg;

    logic [72:0] exp_q[$];
    int          checks;
    int          failures;
    logic [9:0]  exp_commit;
    logic [31:0] exp_dropped;

    rx_mac_interface dut (
        .clk              (clk),
        .reset            (reset),
        .rx_data          (rx_data),
        .rx_data_valid    (rx_data_valid),
        .rx_good_frame    (rx_good_frame),
        .rx_bad_frame     (rx_bad_frame),
        .wr_addr          (wr_addr),
        .wr_data          (wr_data),
        .wr_en            (wr_en),
        .commited_wr_addr (commited_wr_addr),
        .commited_rd_addr (commited_rd_addr),
        .dropped_frames   (dropped_frames),
        .state_dbg        (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write: addr %h data %h, none expected", wr_addr, wr_data);
            end else begin
                logic [72:0] e;
                e = exp_q.pop_front();
                if ({wr_addr, wr_data} !== e) begin
                    failures++;
                    $display("FAIL mem_write: got addr %h data %h expected addr %h data %h",
                             wr_addr, wr_data, e[72:64], e[63:0]);
                end
            end
        end
    end

    // driver tasks
    task automatic cycle(input logic [63:0] d, input logic [7:0] m, input logic g, input logic b);
        rx_data       = d;
        rx_data_valid = m;
        rx_good_frame = g;
        rx_bad_frame  = b;
        @(posedge clk);
        #1;
        rx_data       = 64'd0;
        rx_data_valid = 8'd0;
        rx_good_frame = 1'b0;
        rx_bad_frame  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle(64'd0, 8'd0, 1'b0, 1'b0);
        cycle(64'd0, 8'd0, 1'b0, 1'b0);
        reset       = 1'b0;
        exp_commit  = 10'd0;
        exp_dropped = 32'd0;
    endtask

    task automatic push_write(input logic [9:0] slot, input logic [63:0] d);
        exp_q.push_back({slot[8:0], d});
    endtask

    // n_write: beats expected to reach memory; commits: header + pointer move expected
    task automatic send_frame(input int nbeats, input logic [7:0] last_mask, input logic [9:0] sof,
                              input int n_write, input logic g, input logic b,
                              input logic commits, input logic [31:0] tag);
        logic [31:0] bc;
        logic [63:0] d;
        logic [7:0]  m;
        bc = 32'd0;
        for (int i = 0; i < nbeats; i++) begin
            m  = (i == nbeats - 1) ? last_mask : 8'hFF;
            d  = {tag, 32'(i)};
            bc = bc + 32'($countones(m));
            if (i < n_write) push_write(sof + 10'(1 + i), d);
            cycle(d, m, 1'b0, 1'b0);
        end
        if (commits) push_write(sof, {bc, 32'h0});
        cycle(64'd0, 8'd0, g, b);
        check("commit_e0", 64'(commited_wr_addr), 64'(exp_commit));
        cycle(64'd0, 8'd0, 1'b0, 1'b0);
        check("commit_e1", 64'(commited_wr_addr), 64'(exp_commit));
        if (commits) exp_commit = sof + 10'(1 + nbeats);
        else         exp_dropped = exp_dropped + 32'd1;
        cycle(64'd0, 8'd0, 1'b0, 1'b0);
        check("commit_e2", 64'(commited_wr_addr), 64'(exp_commit));
        check("dropped", 64'(dropped_frames), 64'(exp_dropped));
    endtask

    initial begin
        checks           = 0;
        failures         = 0;
        rx_data          = 64'd0;
        rx_data_valid    = 8'd0;
        rx_good_frame    = 1'b0;
        rx_bad_frame     = 1'b0;
        commited_rd_addr = 10'd0;
        reset            = 1'b1;
        cycle(64'd0, 8'd0, 1'b0, 1'b0);
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_wr_addr", 64'(wr_addr), 64'd0);
        check("rst_wr_data", wr_data, 64'd0);
        check("rst_commit", 64'(commited_wr_addr), 64'd0);
        check("rst_dropped", 64'(dropped_frames), 64'd0);
        check("rst_state", 64'(state_dbg), 64'd0);
        do_reset();

        // 60-byte good frame into empty buffer
        send_frame(8, 8'h0F, 10'd0, 8, 1'b1, 1'b0, 1'b1, 32'h0000_0A01);
        check("good60_commit", 64'(commited_wr_addr), 64'd9);
        // bad frame: data written, no header, slots reused
        send_frame(10, 8'hFF, 10'd9, 10, 1'b0, 1'b1, 1'b0, 32'h0000_0B02);
        check("bad_commit", 64'(commited_wr_addr), 64'd9);
        check("bad_dropped", 64'(dropped_frames), 64'd1);
        // simultaneous good and bad counts as bad
        send_frame(3, 8'h07, 10'd9, 3, 1'b1, 1'b1, 1'b0, 32'h0000_0C03);
        check("both_dropped", 64'(dropped_frames), 64'd2);
        send_frame(2, 8'hFF, 10'd9, 2, 1'b1, 1'b0, 1'b1, 32'h0000_0D04);
        check("reuse_commit", 64'(commited_wr_addr), 64'd12);

        // beat arriving in the COMMIT cycle
        push_write(10'd13, {32'h0000_0E05, 32'd0});
        cycle({32'h0000_0E05, 32'd0}, 8'h3F, 1'b0, 1'b0);
        push_write(10'd12, {32'd6, 32'h0});
        cycle(64'd0, 8'd0, 1'b1, 1'b0);
        check("ifg_commit_e0", 64'(commited_wr_addr), 64'd12);
        cycle({32'h0000_0F06, 32'd0}, 8'hFF, 1'b0, 1'b0);
        check("ifg_commit_e1", 64'(commited_wr_addr), 64'd12);
        cycle({32'h0000_0F06, 32'd1}, 8'hFF, 1'b0, 1'b0);
        check("ifg_commit_e2", 64'(commited_wr_addr), 64'd14);
        cycle({32'h0000_0F06, 32'd2}, 8'h01, 1'b0, 1'b0);
        cycle(64'd0, 8'd0, 1'b1, 1'b0);
        cycle(64'd0, 8'd0, 1'b0, 1'b0);
        check("ifg_dropped", 64'(dropped_frames), 64'd3);
        check("ifg_state", 64'(state_dbg), 64'd0);

        // end pulses while idle are ignored
        cycle(64'd0, 8'd0, 1'b1, 1'b0);
        cycle(64'd0, 8'd0, 1'b0, 1'b1);
        cycle(64'd0, 8'd0, 1'b0, 1'b0);
        check("idle_pulse_dropped", 64'(dropped_frames), 64'd3);
        check("idle_pulse_commit", 64'(commited_wr_addr), 64'd14);

        // overflow at slot 512
        do_reset();
        commited_rd_addr = 10'd0;
        send_frame(499, 8'hFF, 10'd0, 499, 1'b1, 1'b0, 1'b1, 32'h0000_1007);
        check("fill_commit", 64'(commited_wr_addr), 64'd500);
        send_frame(20, 8'hFF, 10'd500, 11, 1'b1, 1'b0, 1'b0, 32'h0000_1108);
        check("ovf_commit", 64'(commited_wr_addr), 64'd500);
        check("ovf_dropped", 64'(dropped_frames), 64'd1);

        // pointer wrap
        do_reset();
        commited_rd_addr = 10'd0;
        send_frame(499, 8'hFF, 10'd0, 499, 1'b1, 1'b0, 1'b1, 32'h0000_2009);
        commited_rd_addr = 10'd500;
        send_frame(499, 8'hFF, 10'd500, 499, 1'b1, 1'b0, 1'b1, 32'h0000_210A);
        commited_rd_addr = 10'd1000;
        send_frame(19, 8'hFF, 10'd1000, 19, 1'b1, 1'b0, 1'b1, 32'h0000_220B);
        check("pre_wrap_commit", 64'(commited_wr_addr), 64'd1020);
        send_frame(8, 8'hFF, 10'd1020, 8, 1'b1, 1'b0, 1'b1, 32'h0000_230C);
        check("wrap_commit", 64'(commited_wr_addr), 64'd5);

        // reset in the middle of a frame
        do_reset();
        commited_rd_addr = 10'd0;
        push_write(10'd1, {32'h0000_300D, 32'd0});
        cycle({32'h0000_300D, 32'd0}, 8'hFF, 1'b0, 1'b0);
        push_write(10'd2, {32'h0000_300D, 32'd1});
        cycle({32'h0000_300D, 32'd1}, 8'hFF, 1'b0, 1'b0);
        reset = 1'b1;
        cycle({32'h0000_300D, 32'd2}, 8'hFF, 1'b0, 1'b0);
        check("mid_rst_wr_en", 64'(wr_en), 64'd0);
        check("mid_rst_wr_addr", 64'(wr_addr), 64'd0);
        check("mid_rst_wr_data", wr_data, 64'd0);
        check("mid_rst_commit", 64'(commited_wr_addr), 64'd0);
        check("mid_rst_dropped", 64'(dropped_frames), 64'd0);
        reset       = 1'b0;
        exp_commit  = 10'd0;
        exp_dropped = 32'd0;
        send_frame(2, 8'h01, 10'd0, 2, 1'b1, 1'b0, 1'b1, 32'h0000_310E);
        check("post_rst_commit", 64'(commited_wr_addr), 64'd3);

        cycle(64'd0, 8'd0, 1'b0, 1'b0);
        cycle(64'd0, 8'd0, 1'b0, 1'b0);
        check("queue_drain", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
